// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM serial link (transmit mux and receive demux).
// Latency: n/a (types and constants only).
// Backpressure: n/a; the serial link is free-running with no flow control.
package tdm_pkg;

    // Four channel slots per frame; the slot index is carried as two bits.
    localparam int NSLOT     = 4;
    localparam int SLOT_BITS = 2;

    // Default serial word width (bits per slot, MSB first).
    localparam int W_DEFAULT = 8;

    // Width of the consecutive-missing-marker counter (covers MISS_MAX up to 7).
    localparam int MISS_BITS = 3;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    // Slot index of the following slot; 3 wraps back to 0.
    function automatic logic [SLOT_BITS-1:0] next_slot(input logic [SLOT_BITS-1:0] s);
        return s + 1'b1;
    endfunction

endpackage

// File: rtl/tdm_frame_aligner.sv
// Frame alignment FSM: tracks bit/slot position, marker misses and emits slot-write strobes.
// Latency: wr_en is combinational for the current cycle; locked/slot/frame_done/sync_err are registered.
// Backpressure: none; one serial bit is consumed every clk.
module tdm_frame_aligner
    import tdm_pkg::*;
#(
    parameter int W        = W_DEFAULT,
    parameter int MISS_MAX = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fsync,
    output logic [SLOT_BITS-1:0] slot,
    output logic                 locked,
    output logic [NSLOT-1:0]     wr_en,
    output logic                 frame_done,
    output logic                 sync_err
);

    localparam int                  CW        = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]       LAST_BIT  = CW'(W - 1);
    localparam logic [CW-1:0]       FIRST_BIT = CW'(1);
    localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(NSLOT - 1);
    localparam logic [MISS_BITS-1:0] MISS_LIM  = MISS_BITS'(MISS_MAX);

    tdm_state_e           state_q,      state_d;
    logic [CW-1:0]        bit_cnt_q,    bit_cnt_d;
    logic [SLOT_BITS-1:0] slot_q,       slot_d;
    logic [MISS_BITS-1:0] miss_cnt_q,   miss_cnt_d;
    logic                 frame_done_q, frame_done_d;
    logic                 sync_err_q,   sync_err_d;
    logic [NSLOT-1:0]     wr_en_d;

    // The only place a marker is legal once aligned: MSB of slot 0.
    logic at_marker;
    assign at_marker = (bit_cnt_q == '0) && (slot_q == '0);

    // Next-state logic for alignment, counters and strobes.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        slot_d       = slot_q;
        miss_cnt_d   = miss_cnt_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        wr_en_d      = '0;

        case (state_q)
            HUNT: begin
                // The marker cycle carries the MSB of slot 0, so counting resumes at bit 1.
                if (fsync) begin
                    state_d    = LOCKED;
                    bit_cnt_d  = FIRST_BIT;
                    slot_d     = '0;
                    miss_cnt_d = '0;
                end
            end

            LOCKED: begin
                if (fsync && !at_marker) begin
                    // Misplaced marker: trust it, drop the partial word/frame and realign here.
                    sync_err_d = 1'b1;
                    bit_cnt_d  = FIRST_BIT;
                    slot_d     = '0;
                    miss_cnt_d = '0;
                end else if (at_marker && !fsync && (miss_cnt_q + 1'b1 == MISS_LIM)) begin
                    // Too many consecutive missing markers: give up and hunt again.
                    state_d    = HUNT;
                    bit_cnt_d  = '0;
                    slot_d     = '0;
                    miss_cnt_d = '0;
                end else begin
                    // A missing marker is tolerated; the frame is still received.
                    if (at_marker) begin
                        miss_cnt_d = fsync ? '0 : miss_cnt_q + 1'b1;
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        wr_en_d[slot_q] = 1'b1;
                        bit_cnt_d       = '0;
                        slot_d          = next_slot(slot_q);
                        frame_done_d    = (slot_q == LAST_SLOT);
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d    = HUNT;
                bit_cnt_d  = '0;
                slot_d     = '0;
                miss_cnt_d = '0;
            end
        endcase
    end

    // State and counter registers; reset overrides any marker in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            slot_q       <= '0;
            miss_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            slot_q       <= slot_d;
            miss_cnt_q   <= miss_cnt_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    // wr_en must be combinational so the output register loads on the edge that
    // consumes the word's last bit. Reset suppresses it so a reset cycle writes nothing.
    assign wr_en      = rst ? '0 : wr_en_d;
    assign slot       = slot_q;
    assign locked     = (state_q == LOCKED);
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: rtl/tdm_demux_1to4.sv
// 1-to-4 TDM demultiplexer: deserialises four W-bit slots per frame into registered channel words.
// Latency: one edge from a slot's last serial bit to its output; frame_valid on the same edge as o3.
// Backpressure: none; outputs hold until overwritten and consumers must keep up with the line rate.
module tdm_demux_1to4
    import tdm_pkg::*;
#(
    parameter int W        = W_DEFAULT,
    parameter int MISS_MAX = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    input  logic         fsync,
    output logic [W-1:0] o0,
    output logic [W-1:0] o1,
    output logic [W-1:0] o2,
    output logic [W-1:0] o3,
    output logic         s1,
    output logic         s0,
    output logic         locked,
    output logic         frame_valid,
    output logic         sync_err
);

    logic [SLOT_BITS-1:0] slot;
    logic [NSLOT-1:0]     wr_en;

    // The shift register runs every cycle; the aligner decides when its contents
    // form a complete word, so partial words are discarded simply by not writing them.
    logic [W-1:0] shreg_q, shreg_d;
    logic [W-1:0] o_q [NSLOT];
    logic [W-1:0] o_d [NSLOT];

    tdm_frame_aligner #(
        .W        (W),
        .MISS_MAX (MISS_MAX)
    ) u_aligner (
        .clk        (clk),
        .rst        (rst),
        .fsync      (fsync),
        .slot       (slot),
        .locked     (locked),
        .wr_en      (wr_en),
        .frame_done (frame_valid),
        .sync_err   (sync_err)
    );

    // Shift in the new bit; the strobed slot captures the completed word.
    always_comb begin
        shreg_d = {shreg_q[W-2:0], din};
        for (int k = 0; k < NSLOT; k++) begin
            o_d[k] = wr_en[k] ? shreg_d : o_q[k];
        end
    end

    // Shift register and channel output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            for (int k = 0; k < NSLOT; k++) begin
                o_q[k] <= '0;
            end
        end else begin
            shreg_q <= shreg_d;
            for (int k = 0; k < NSLOT; k++) begin
                o_q[k] <= o_d[k];
            end
        end
    end

    assign o0 = o_q[0];
    assign o1 = o_q[1];
    assign o2 = o_q[2];
    assign o3 = o_q[3];
    assign s1 = slot[1];
    assign s0 = slot[0];

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Scoreboard bench for tdm_demux_1to4 (W=8, MISS_MAX=2) with directed serial frames.
// Latency: frame_valid expected in cycle t0+32 for a marker in cycle t0; sync_err one cycle after a bad marker.
// Backpressure: none; stimulus drives one bit per clock.
module tb_tdm_demux_1to4;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         din = 1'b0;
    logic         fsync = 1'b0;
    logic [W-1:0] o0, o1, o2, o3;
    logic         s1, s0, locked, frame_valid, sync_err;

    tdm_demux_1to4 #(
        .W        (W),
        .MISS_MAX (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .fsync       (fsync),
        .o0          (o0),
        .o1          (o1),
        .o2          (o2),
        .o3          (o3),
        .s1          (s1),
        .s0          (s0),
        .locked      (locked),
        .frame_valid (frame_valid),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    // Cycle index: during cycle n (between edges), cyc == n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [31:0] words;
    } frame_exp_t;

    frame_exp_t fq[$];
    int         sq[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected frames / sync errors when due and checks every pulse.
    logic fv_due, se_due;
    always @(negedge clk) begin
        fv_due = (fq.size() > 0) && (fq[0].at == cyc);
        if (frame_valid || fv_due) begin
            check("frame_valid_timing", 64'(frame_valid), 64'(fv_due));
            if (fv_due) begin
                if (frame_valid) begin
                    check("frame_words", 64'({o0, o1, o2, o3}), 64'(fq[0].words));
                end
                void'(fq.pop_front());
            end
        end
        se_due = (sq.size() > 0) && (sq[0] == cyc);
        if (sync_err || se_due) begin
            check("sync_err_timing", 64'(sync_err), 64'(se_due));
            if (se_due) void'(sq.pop_front());
        end
    end

    task automatic send_bit(input logic d, input logic fs);
        din   = d;
        fsync = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic mark);
        for (int i = 7; i >= 0; i--) send_bit(w[i], mark && (i == 7));
    endtask

    task automatic send_frame(input logic [31:0] ws, input logic mark);
        fq.push_back('{at: cyc + 32, words: ws});
        send_word(ws[31:24], mark);
        send_word(ws[23:16], 1'b0);
        send_word(ws[15:8],  1'b0);
        send_word(ws[7:0],   1'b0);
    endtask

    task automatic check_outs(input string name, input logic [31:0] exp);
        check(name, 64'({o0, o1, o2, o3}), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int ts;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) send_bit(1'b1, 1'b0);
        check_outs("reset_outs", 32'h0);
        check("reset_locked", 64'(locked), 64'd0);
        check("reset_slot", 64'({s1, s0}), 64'd0);
        check("reset_fv", 64'(frame_valid), 64'd0);
        check("reset_se", 64'(sync_err), 64'd0);
        rst = 1'b0;

        // HUNT ignores data without a marker
        repeat (5) send_bit(1'b1, 1'b0);
        check("hunt_locked", 64'(locked), 64'd0);
        check_outs("hunt_outs", 32'h0);

        // Basic frame
        send_frame(32'hA53C0FF0, 1'b1);
        check("basic_locked", 64'(locked), 64'd1);
        check_outs("basic_outs", 32'hA53C0FF0);

        // Back-to-back frames
        send_frame(32'h11223344, 1'b1);
        send_frame(32'h55667788, 1'b1);
        send_frame(32'h99AABBCC, 1'b1);

        // Misplaced marker at slot 2, bit 3
        send_word(8'hDE, 1'b1);
        check("mis_slot1", 64'({s1, s0}), 64'd1);
        send_word(8'hAD, 1'b0);
        check("mis_slot2", 64'({s1, s0}), 64'd2);
        check_outs("mis_partial", 32'hDEADBBCC);
        repeat (3) send_bit(1'b1, 1'b0);
        ts = cyc;
        sq.push_back(ts + 1);
        fq.push_back('{at: ts + 32, words: 32'h12345678});
        send_word(8'h12, 1'b1);
        check_outs("realign_keep", 32'h12ADBBCC);
        check("realign_locked", 64'(locked), 64'd1);
        send_word(8'h34, 1'b0);
        send_word(8'h56, 1'b0);
        send_word(8'h78, 1'b0);

        // Loss of lock: markers stop
        send_frame(32'h01020304, 1'b0);
        check("miss1_locked", 64'(locked), 64'd1);
        send_bit(1'b1, 1'b0);
        check("miss2_locked", 64'(locked), 64'd0);
        check("miss2_slot", 64'({s1, s0}), 64'd0);
        send_word(8'hFF, 1'b0);
        send_word(8'h5A, 1'b0);
        check("lost_locked", 64'(locked), 64'd0);
        check_outs("lost_hold", 32'h01020304);
        send_frame(32'hC1C2C3C4, 1'b1);
        check("relock_locked", 64'(locked), 64'd1);

        // Reset mid-frame at slot 1, bit 4
        send_word(8'hE1, 1'b1);
        check("pre_rst_o0", 64'(o0), 64'hE1);
        repeat (4) send_bit(1'b1, 1'b0);
        rst = 1'b1;
        send_bit(1'b1, 1'b0);
        rst = 1'b0;
        check_outs("rst_mid_outs", 32'h0);
        check("rst_mid_locked", 64'(locked), 64'd0);
        check("rst_mid_slot", 64'({s1, s0}), 64'd0);
        send_word(8'hA5, 1'b0);
        send_word(8'h3C, 1'b0);
        check("rst_idle_locked", 64'(locked), 64'd0);
        check_outs("rst_idle_outs", 32'h0);

        // Reset and marker in the same cycle: reset wins
        rst = 1'b1;
        send_bit(1'b1, 1'b1);
        rst = 1'b0;
        check("rst_fsync_locked", 64'(locked), 64'd0);
        send_word(8'hFF, 1'b0);
        check("rst_fsync_after", 64'(locked), 64'd0);
        check_outs("rst_fsync_outs", 32'h0);

        // Drain and confirm every expected pulse was seen
        repeat (4) send_bit(1'b0, 1'b0);
        check("frames_pending", 64'(fq.size()), 64'd0);
        check("syncerr_pending", 64'(sq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
